// File: rtl/fb_write_responder.sv
// fb_write_responder
//   Responder end of the frame-buffer write bus. Each frame it grants the bus
//   to write sources 0..MAX_WRITE_SOURCE in order, accepts their pixel stream,
//   drops transparent / off-screen pixels and issues registered write strobes
//   to the back bank of a double-buffered pixel RAM. The display bank swaps on
//   the first frame pulse seen after a completed pass.
// Ports:
//   clk, resetN            pixel clock, async active-low reset
//   frame                  one-cycle pulse at start of vertical blank
//   write_color_data/_transparent/_x_addr/_y_addr/_active
//                          pixel bus from the granted source
//   write_awaited          responder is taking pixels from the granted source
//   write_source_sel       index of the granted source
//   ram_wr_en/_addr/_data  one-cycle write strobe into pixel RAM
//   ram_wr_bank            bank being written (inverse of display_bank)
//   display_bank           bank the screen reader uses
//   frame_overrun          sticky: frame pulse arrived during a pass
module fb_write_responder #(
  parameter int MAX_WRITE_SOURCE = 1,
  parameter int COLOR_DEPTH      = 9,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int START_TIMEOUT    = 16,
  localparam int SEL_W = (MAX_WRITE_SOURCE > 0) ? $clog2(MAX_WRITE_SOURCE + 1) : 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic                   write_transparent,
  input  logic [31:0]            write_x_addr,
  input  logic [31:0]            write_y_addr,
  input  logic                   write_active,
  output logic                   write_awaited,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic                   ram_wr_en,
  output logic [18:0]            ram_wr_addr,
  output logic [COLOR_DEPTH-1:0] ram_wr_data,
  output logic                   ram_wr_bank,
  output logic                   display_bank,
  output logic                   frame_overrun
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    GRANT,
    STREAM,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   display_bank_q, display_bank_d;
  logic                   frame_overrun_q, frame_overrun_d;
  logic                   write_awaited_q, write_awaited_d;
  logic [SEL_W-1:0]       write_source_sel_q, write_source_sel_d;
  logic                   ram_wr_en_q, ram_wr_en_d;
  logic [18:0]            ram_wr_addr_q, ram_wr_addr_d;
  logic [COLOR_DEPTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic                   accept;
  logic                   advance;

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    cnt_d           = cnt_q;
    display_bank_d  = display_bank_q;
    frame_overrun_d = frame_overrun_q;
    accept          = 1'b0;
    advance         = 1'b0;

    case (state_q)
      WAIT_FRAME: begin
        if (frame) begin
          state_d = GRANT;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (frame) frame_overrun_d = 1'b1;
        if (write_active) begin
          accept  = 1'b1;
          state_d = STREAM;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (frame) frame_overrun_d = 1'b1;
        if (write_active) accept  = 1'b1;
        else              advance = 1'b1;
      end
      DONE: begin
        if (frame) begin
          display_bank_d = ~display_bank_q;
          sel_d          = '0;
          cnt_d          = '0;
          state_d        = GRANT;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase

    // Advance is shared by the timeout skip and the end of a stream.
    if (advance) begin
      if (sel_q < SEL_W'(MAX_WRITE_SOURCE)) begin
        sel_d   = sel_q + 1'b1;
        cnt_d   = '0;
        state_d = GRANT;
      end else begin
        state_d = DONE;
      end
    end
  end

  // Handshake outputs lag the state register by one cycle.
  always_comb begin
    write_awaited_d    = (state_q == GRANT) || (state_q == STREAM);
    write_source_sel_d = sel_q;
  end

  always_comb begin
    ram_wr_en_d   = accept && !write_transparent &&
                    (write_x_addr < 32'(SCREEN_WIDTH)) &&
                    (write_y_addr < 32'(SCREEN_HEIGHT));
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    if (ram_wr_en_d) begin
      ram_wr_addr_d = 19'(write_y_addr * 32'(SCREEN_WIDTH) + write_x_addr);
      ram_wr_data_d = write_color_data;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q            <= WAIT_FRAME;
      sel_q              <= '0;
      cnt_q              <= '0;
      display_bank_q     <= 1'b0;
      frame_overrun_q    <= 1'b0;
      write_awaited_q    <= 1'b0;
      write_source_sel_q <= '0;
      ram_wr_en_q        <= 1'b0;
      ram_wr_addr_q      <= '0;
      ram_wr_data_q      <= '0;
    end else begin
      state_q            <= state_d;
      sel_q              <= sel_d;
      cnt_q              <= cnt_d;
      display_bank_q     <= display_bank_d;
      frame_overrun_q    <= frame_overrun_d;
      write_awaited_q    <= write_awaited_d;
      write_source_sel_q <= write_source_sel_d;
      ram_wr_en_q        <= ram_wr_en_d;
      ram_wr_addr_q      <= ram_wr_addr_d;
      ram_wr_data_q      <= ram_wr_data_d;
    end
  end

  assign write_awaited    = write_awaited_q;
  assign write_source_sel = write_source_sel_q;
  assign ram_wr_en        = ram_wr_en_q;
  assign ram_wr_addr      = ram_wr_addr_q;
  assign ram_wr_data      = ram_wr_data_q;
  assign display_bank     = display_bank_q;
  assign ram_wr_bank      = ~display_bank_q;
  assign frame_overrun    = frame_overrun_q;

endmodule

// File: tb/tb_fb_write_responder.sv
// tb_fb_write_responder
//   Self-checking bench for fb_write_responder: inline checks per scenario plus
//   a write scoreboard fed when pixels are driven and drained on ram_wr_en.
module tb_fb_write_responder;

  logic        clk;
  logic        resetN;
  logic        frame;
  logic [8:0]  write_color_data;
  logic        write_transparent;
  logic [31:0] write_x_addr;
  logic [31:0] write_y_addr;
  logic        write_active;
  logic        write_awaited;
  logic [0:0]  write_source_sel;
  logic        ram_wr_en;
  logic [18:0] ram_wr_addr;
  logic [8:0]  ram_wr_data;
  logic        ram_wr_bank;
  logic        display_bank;
  logic        frame_overrun;

  typedef struct packed {
    logic [18:0] addr;
    logic [8:0]  data;
    logic        bank;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;
  logic disp_model = 1'b0;

  fb_write_responder #(
    .MAX_WRITE_SOURCE(1),
    .COLOR_DEPTH(9),
    .SCREEN_WIDTH(640),
    .SCREEN_HEIGHT(480),
    .START_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .frame(frame),
    .write_color_data(write_color_data),
    .write_transparent(write_transparent),
    .write_x_addr(write_x_addr),
    .write_y_addr(write_y_addr),
    .write_active(write_active),
    .write_awaited(write_awaited),
    .write_source_sel(write_source_sel),
    .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_wr_bank(ram_wr_bank),
    .display_bank(display_bank),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard drain: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_wr_en) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_write got addr=%0d data=%h bank=%0d exp none",
                 ram_wr_addr, ram_wr_data, ram_wr_bank);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({ram_wr_addr, ram_wr_data, ram_wr_bank} !== e)
          $display("FAIL sb_write got addr=%0d data=%h bank=%0d exp addr=%0d data=%h bank=%0d",
                   ram_wr_addr, ram_wr_data, ram_wr_bank, e.addr, e.data, e.bank);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input logic [8:0] c, input logic t);
    exp_t e;
    write_x_addr      = 32'(x);
    write_y_addr      = 32'(y);
    write_color_data  = c;
    write_transparent = t;
    write_active      = 1'b1;
    if (!t && x < 640 && y < 480) begin
      e.addr = 19'(y * 640 + x);
      e.data = c;
      e.bank = ~disp_model;
      sb_q.push_back(e);
    end
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame             = 1'($urandom);
      write_color_data  = 9'($urandom);
      write_transparent = 1'($urandom);
      write_x_addr      = $urandom;
      write_y_addr      = $urandom;
      write_active      = 1'($urandom);
      tick();
    end
    total++; if (write_awaited !== 1'b0) $display("FAIL rst_awaited got=%0d exp=0", write_awaited); else passed++;
    total++; if (write_source_sel !== 1'b0) $display("FAIL rst_sel got=%0d exp=0", write_source_sel); else passed++;
    total++; if (ram_wr_en !== 1'b0) $display("FAIL rst_wr_en got=%0d exp=0", ram_wr_en); else passed++;
    total++; if (ram_wr_addr !== 19'd0) $display("FAIL rst_addr got=%0d exp=0", ram_wr_addr); else passed++;
    total++; if (ram_wr_data !== 9'd0) $display("FAIL rst_data got=%h exp=0", ram_wr_data); else passed++;
    total++; if (display_bank !== 1'b0) $display("FAIL rst_disp got=%0d exp=0", display_bank); else passed++;
    total++; if (ram_wr_bank !== 1'b1) $display("FAIL rst_wr_bank got=%0d exp=1", ram_wr_bank); else passed++;
    total++; if (frame_overrun !== 1'b0) $display("FAIL rst_overrun got=%0d exp=0", frame_overrun); else passed++;
    frame = 1'b0; write_active = 1'b0; write_transparent = 1'b0;
    resetN = 1'b1;
    tick();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    total++; if (write_awaited !== 1'b0) $display("FAIL start_awaited_lag got=%0d exp=0", write_awaited); else passed++;
    tick();
    total++; if (write_awaited !== 1'b1) $display("FAIL start_awaited got=%0d exp=1", write_awaited); else passed++;
    total++; if (write_source_sel !== 1'b0) $display("FAIL start_sel got=%0d exp=0", write_source_sel); else passed++;
    total++; if (display_bank !== 1'b0) $display("FAIL start_disp got=%0d exp=0", display_bank); else passed++;
  endtask

  task automatic test_single_stream();
    drive_px(0, 0, 9'h1FF, 1'b0);
    total++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 19'd0)
      $display("FAIL stream_latency got en=%0d addr=%0d exp en=1 addr=0", ram_wr_en, ram_wr_addr); else passed++;
    drive_px(639, 479, 9'h007, 1'b0);
    drive_px(5, 1, 9'h0A0, 1'b0);
  endtask

  task automatic test_filtering();
    drive_px(640, 0, 9'h1AA, 1'b0);
    drive_px(0, 480, 9'h1AB, 1'b0);
    drive_px(3, 3, 9'h0F0, 1'b1);
    drive_px(3, 3, 9'h011, 1'b0);
    write_active = 1'b0;
    write_transparent = 1'b0;
    tick();
    total++; if (write_source_sel !== 1'b0) $display("FAIL sel_lag got=%0d exp=0", write_source_sel); else passed++;
    total++; if (write_awaited !== 1'b1) $display("FAIL awaited_between got=%0d exp=1", write_awaited); else passed++;
    tick();
    total++; if (write_source_sel !== 1'b1) $display("FAIL sel_next got=%0d exp=1", write_source_sel); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (write_awaited === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++; if (n != 16) $display("FAIL timeout_cycles got=%0d exp=16", n); else passed++;
    total++; if (write_source_sel !== 1'b1) $display("FAIL done_sel got=%0d exp=1", write_source_sel); else passed++;
    total++; if (display_bank !== 1'b0) $display("FAIL done_disp got=%0d exp=0", display_bank); else passed++;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    disp_model = ~disp_model;
    total++; if (display_bank !== 1'b1) $display("FAIL swap_disp got=%0d exp=1", display_bank); else passed++;
    total++; if (ram_wr_bank !== 1'b0) $display("FAIL swap_wr_bank got=%0d exp=0", ram_wr_bank); else passed++;
  endtask

  task automatic test_overrun();
    tick();
    drive_px(10, 2, 9'h055, 1'b0);
    frame = 1'b1;
    drive_px(11, 2, 9'h056, 1'b0);
    frame = 1'b0;
    total++; if (frame_overrun !== 1'b1) $display("FAIL overrun_set got=%0d exp=1", frame_overrun); else passed++;
    total++; if (display_bank !== 1'b1) $display("FAIL overrun_noswap got=%0d exp=1", display_bank); else passed++;
    drive_px(12, 2, 9'h057, 1'b0);
    write_active = 1'b0;
    tick();
    tick();
    drive_px(0, 0, 9'h123, 1'b0);
    write_active = 1'b0;
    tick();
    total++; if (display_bank !== 1'b1) $display("FAIL predone_disp got=%0d exp=1", display_bank); else passed++;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    disp_model = ~disp_model;
    total++; if (display_bank !== 1'b0) $display("FAIL swap2_disp got=%0d exp=0", display_bank); else passed++;
    total++; if (ram_wr_bank !== 1'b1) $display("FAIL swap2_wr_bank got=%0d exp=1", ram_wr_bank); else passed++;
    total++; if (frame_overrun !== 1'b1) $display("FAIL overrun_sticky got=%0d exp=1", frame_overrun); else passed++;
  endtask

  task automatic test_reset_mid_stream();
    tick();
    drive_px(1, 1, 9'h0AA, 1'b0);
    // Second pixel is accepted, but reset lands before its strobe is sampled.
    write_x_addr     = 32'd2;
    write_color_data = 9'h0AB;
    tick();
    total++; if (ram_wr_en !== 1'b1) $display("FAIL mid_pre_en got=%0d exp=1", ram_wr_en); else passed++;
    resetN = 1'b0;
    #1;
    total++; if (ram_wr_en !== 1'b0) $display("FAIL mid_rst_en got=%0d exp=0", ram_wr_en); else passed++;
    total++; if (write_awaited !== 1'b0) $display("FAIL mid_rst_awaited got=%0d exp=0", write_awaited); else passed++;
    total++; if (frame_overrun !== 1'b0) $display("FAIL mid_rst_overrun got=%0d exp=0", frame_overrun); else passed++;
    total++; if (display_bank !== 1'b0 || ram_wr_bank !== 1'b1)
      $display("FAIL mid_rst_banks got disp=%0d wr=%0d exp disp=0 wr=1", display_bank, ram_wr_bank); else passed++;
    disp_model = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++; if (write_awaited !== 1'b0) $display("FAIL post_rst_idle got=%0d exp=0", write_awaited); else passed++;
    write_active = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    total++; if (write_awaited !== 1'b1) $display("FAIL post_rst_start got=%0d exp=1", write_awaited); else passed++;
    for (int i = 0; i < 3; i++) tick();
    total++; if (sb_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); else passed++;
  endtask

  initial begin
    resetN            = 1'b1;
    frame             = 1'b0;
    write_color_data  = '0;
    write_transparent = 1'b0;
    write_x_addr      = '0;
    write_y_addr      = '0;
    write_active      = 1'b0;
    #2;
    test_reset();
    test_single_stream();
    test_filtering();
    test_timeout();
    test_overrun();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/fb_write_responder.md
# fb_write_responder

Responder end of the frame-buffer write bus driven by the drawing units (background, starfield, and later sprites). Once per frame it grants the shared bus to each write source in index order and accepts their pixel stream. It drops transparent and off-screen pixels and turns accepted pixels into registered write strobes for the back bank of a double-buffered pixel RAM. The display bank swaps only on a frame pulse that follows a completed pass.

## Interface
Parameters:
- MAX_WRITE_SOURCE, 1: highest source index; sources are 0..MAX_WRITE_SOURCE.
- COLOR_DEPTH, 9: pixel width in bits.
- SCREEN_WIDTH, 640: visible columns.
- SCREEN_HEIGHT, 480: visible rows.
- START_TIMEOUT, 16: cycles a granted source has to raise write_active before it is skipped.

Ports:
- clk  in  1  pixel clock (clk_25 domain).
- resetN  in  1  asynchronous, active-low reset.
- frame  in  1  one-cycle pulse at the start of vertical blank.
- write_color_data  in  COLOR_DEPTH  pixel colour from the granted source.
- write_transparent  in  1  pixel is transparent; do not store it.
- write_x_addr  in  32  pixel column.
- write_y_addr  in  32  pixel row.
- write_active  in  1  granted source presents a valid pixel.
- write_awaited  out  1  responder accepts pixels from the granted source.
- write_source_sel  out  $clog2(MAX_WRITE_SOURCE+1)  index of the granted source.
- ram_wr_en  out  1  write strobe to pixel RAM.
- ram_wr_addr  out  19  y*SCREEN_WIDTH+x.
- ram_wr_data  out  COLOR_DEPTH  pixel to store.
- ram_wr_bank  out  1  bank being written (always ~display_bank).
- display_bank  out  1  bank the screen reader uses.
- frame_overrun  out  1  sticky; a frame pulse arrived while a pass was still running.

## Operation
- States:
  - WAIT_FRAME: reset state.
  - GRANT: awaiting source start.
  - STREAM: source sending.
  - DONE: pass complete, awaiting swap.
- WAIT_FRAME: on frame, go to GRANT with sel=0 and no bank swap.
- GRANT: write_awaited=1 and the timeout counter runs.
  - write_active=1: go to STREAM. This cycle is an accepted pixel.
  - Counter reaches START_TIMEOUT-1 with write_active=0: source is skipped and the pass advances.
- STREAM: write_awaited=1.
  - Each cycle with write_active=1 is one accepted pixel.
  - First cycle with write_active=0 ends this source's turn and the pass advances.
- Advance:
  - sel<MAX_WRITE_SOURCE: sel+1, return to GRANT, counter cleared.
  - Otherwise: go to DONE with sel held.
- DONE: write_awaited=0. On frame, toggle display_bank, set sel=0, go to GRANT.
- Frame pulse in GRANT or STREAM sets frame_overrun and does not swap or interrupt the pass. The swap waits for the first frame seen in DONE.
- Pixel filter on an accepted pixel: no RAM write if any of these holds:
  - write_transparent=1
  - x ≥ SCREEN_WIDTH
  - y ≥ SCREEN_HEIGHT
  
  The pixel still counts as accepted.
- Address: y*SCREEN_WIDTH+x, computed in 32 bits and truncated to 19 bits. It is only used when in range.
- frame_overrun clears only on reset.

## Timing
- Reset values:
  - write_awaited=0, write_source_sel=0
  - ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0
  - display_bank=0, ram_wr_bank=1
  - frame_overrun=0
  - state WAIT_FRAME
- write_awaited and write_source_sel are registered. They change the cycle after the state transition that causes them.
- Write latency: pixel accepted at edge N produces ram_wr_en=1 with addr/data during cycle N+1, for exactly one cycle per accepted pixel.
- ram_wr_en is 0 in every cycle without a qualifying accepted pixel.
- display_bank toggles on the edge that samples frame in DONE. ram_wr_bank follows on the same edge.
- A pixel accepted on the last STREAM cycle before the swap is still written to the old back bank.
- Skip cost: exactly START_TIMEOUT cycles in GRANT.
- Reset asserted mid-pass returns all outputs to reset values immediately (asynchronously), with no further RAM writes.

## Test plan
- Reset: hold resetN=0 with random inputs -> all outputs at reset values; pulse frame -> write_awaited=1 with sel=0 two edges after the pulse, display_bank stays 0.
- Single stream: source 0 sends (0,0,9'h1FF), (639,479,9'h007), (5,1,9'h0A0), then drops active -> ram_wr_en pulses with addr 0, 307199, 645 and matching data, each one cycle after acceptance; sel becomes 1.
- Filtering: pixels (640,0), (0,480), and (3,3) with transparent=1 -> no ram_wr_en; next pixel (3,3,9'h011) opaque -> write at addr 1923.
- Timeout: source 1 never raises active -> DONE after exactly 16 cycles in GRANT; next frame toggles display_bank to 1 and ram_wr_bank to 0.
- Overrun: frame pulse mid-STREAM -> frame_overrun=1, no swap; swap happens on the first frame after DONE.
- Reset mid-STREAM: resetN low during a burst -> ram_wr_en=0 immediately, state returns to WAIT_FRAME, display_bank=0.
